// File: rtl/xbus_spike_responder.sv
// ---------------------------------------------------------------------------
// xbus_spike_responder
//
// XBUS (pipelined Wishbone-style) target on the NEORV32 external bus. The CPU
// programs a small register bank and pushes 32-bit spike words into an event
// FIFO. The neuromorphic accelerator drains that FIFO through a valid/ready
// stream.
//
// Register window (256 bytes at BASE_ADDR, word offsets):
//   0x00 CTRL     RW  bit0 enable, bit1 flush (write-1, self-clearing)
//   0x04 STATUS   RO  bit0 empty, bit1 full, [15:8] level, bit16 overflow
//                     (sticky; write 1 with sel[2] to clear)
//   0x08 PUSH     WO  full-word push into the event FIFO
//   0x0C SCRATCH  RW  byte-granular
//   0x10 TSTAMP   RO  free-running cycle counter, only when the macro
//                     XBUS_SPIKE_TSTAMP_EN is defined (otherwise err)
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   xbus_adr_i/dat_i/tag_i/ request side of the bus (tag is ignored)
//   we_i/sel_i/stb_i/cyc_i
//   xbus_dat_o/ack_o/err_o  response side; dat_o is 0 outside ack
//   evt_data_o/evt_valid_o  FIFO head word and valid toward the accelerator
//   evt_ready_i             accelerator accepts the head word
//
// Parameters: BASE_ADDR (window base), FIFO_DEPTH (power of 2, 2..256),
// WAIT_CYCLES (0..15 extra cycles before the response).
// ---------------------------------------------------------------------------
module xbus_spike_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] xbus_adr_i,
  input  logic [31:0] xbus_dat_i,
  input  logic [2:0]  xbus_tag_i,
  input  logic        xbus_we_i,
  input  logic [3:0]  xbus_sel_i,
  input  logic        xbus_stb_i,
  input  logic        xbus_cyc_i,
  output logic [31:0] xbus_dat_o,
  output logic        xbus_ack_o,
  output logic        xbus_err_o,
  output logic [31:0] evt_data_o,
  output logic        evt_valid_o,
  input  logic        evt_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = 4;

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_PUSH    = 6'h02;
  localparam logic [5:0] OFF_SCRATCH = 6'h03;
  localparam logic [5:0] OFF_TSTAMP  = 6'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt, wcnt_nxt;

  // Latched request (data path, not reset)
  logic [5:0]        req_off;
  logic              req_we;
  logic [3:0]        req_sel;
  logic [31:0]       req_dat;

  // Register bank
  logic              ctrl_en;
  logic              ovf;
  logic [31:0]       scratch;

  // Event FIFO
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              empty, full, pop, full_after_pop;

  // Decode / response
  logic              hit, accept, resp_live;
  logic              resp_err;
  logic [31:0]       rdata;
  logic [31:0]       status_word;
  logic              wr_fire, push_ok, flush, ovf_set, ovf_clr;

  // Address bits below the word and the tag carry no meaning here.
  logic              unused_bits;
  assign unused_bits = ^{xbus_tag_i, xbus_adr_i[1:0]};

  assign hit       = (xbus_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept    = (state == ST_IDLE) && xbus_stb_i && xbus_cyc_i && hit;
  // A dropped cyc in RESP aborts the transfer: no response, no side effect.
  assign resp_live = (state == ST_RESP) && xbus_cyc_i;

  // -------------------------------------------------------------------------
  // Request capture / FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!xbus_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (wcnt == '0) begin
          state_nxt = ST_RESP;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_off <= xbus_adr_i[7:2];
      req_we  <= xbus_we_i;
      req_sel <= xbus_sel_i;
      req_dat <= xbus_dat_i;
    end
  end

  // -------------------------------------------------------------------------
  // Response decode (RESP cycle)
  // -------------------------------------------------------------------------
  // Level occupies 8 bits; with FIFO_DEPTH = 256 a full FIFO reads level 0
  // and the full flag disambiguates.
  assign status_word = {15'b0, ovf, 8'(level), 6'b0, full, empty};

`ifdef XBUS_SPIKE_TSTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tstamp <= '0;
    else       tstamp <= tstamp + 32'd1;
  end
`endif

  always_comb begin
    resp_err = 1'b0;
    rdata    = '0;
    case (req_off)
      OFF_CTRL:    rdata = {31'b0, ctrl_en};
      OFF_STATUS:  rdata = status_word;
      OFF_PUSH:    resp_err = !req_we || (req_sel != 4'hF) || full_after_pop;
      OFF_SCRATCH: rdata = scratch;
`ifdef XBUS_SPIKE_TSTAMP_EN
      OFF_TSTAMP:  rdata = tstamp;
`endif
      default:     resp_err = 1'b1;
    endcase
  end

  assign xbus_ack_o = resp_live && !resp_err;
  assign xbus_err_o = resp_live && resp_err;
  assign xbus_dat_o = xbus_ack_o ? rdata : 32'h0;

  assign wr_fire = xbus_ack_o && req_we;
  assign flush   = wr_fire && (req_off == OFF_CTRL) && req_sel[0] && req_dat[1];
  assign ovf_clr = wr_fire && (req_off == OFF_STATUS) && req_sel[2] && req_dat[16];
  assign push_ok = wr_fire && (req_off == OFF_PUSH);
  // Only a well-formed push that meets a full FIFO counts as overflow.
  assign ovf_set = resp_live && req_we && (req_off == OFF_PUSH) &&
                   (req_sel == 4'hF) && full_after_pop;

  // -------------------------------------------------------------------------
  // Register bank commit
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en <= 1'b0;
      ovf     <= 1'b0;
      scratch <= '0;
    end else begin
      if (wr_fire && (req_off == OFF_CTRL) && req_sel[0]) ctrl_en <= req_dat[0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (wr_fire && (req_off == OFF_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (req_sel[b]) scratch[8*b +: 8] <= req_dat[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO
  // -------------------------------------------------------------------------
  assign empty          = (level == '0);
  assign full           = (level == LVL_W'(FIFO_DEPTH));
  assign evt_valid_o    = ctrl_en && !empty;
  assign pop            = evt_valid_o && evt_ready_i;
  // A same-cycle pop frees a slot for the incoming push.
  assign full_after_pop = full && !pop;
  assign evt_data_o     = empty ? 32'h0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= req_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      // Flush wins over any pop in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_spike_responder.sv
// ---------------------------------------------------------------------------
// tb_xbus_spike_responder
//
// Directed bench for xbus_spike_responder. Instance u_dut0 uses zero wait
// states; u_dut1 uses WAIT_CYCLES = 3 for latency and abort scenarios. Both
// share the address/data/sel/we lines but have their own stb/cyc/ready.
// ---------------------------------------------------------------------------
module tb_xbus_spike_responder;

  localparam logic [31:0] B = 32'hF000_0000;
  localparam int RESP_NONE = 0;
  localparam int RESP_ACK  = 1;
  localparam int RESP_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [2:0]  tag = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb0 = 1'b0, cyc0 = 1'b0, rdy0 = 1'b0;
  logic        stb1 = 1'b0, cyc1 = 1'b0, rdy1 = 1'b0;

  logic [31:0] dat0, dat1, evd0, evd1;
  logic        ack0, err0, evv0, ack1, err1, evv1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xbus_spike_responder #(.BASE_ADDR(B), .FIFO_DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat), .xbus_tag_i(tag),
    .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb0), .xbus_cyc_i(cyc0),
    .xbus_dat_o(dat0), .xbus_ack_o(ack0), .xbus_err_o(err0),
    .evt_data_o(evd0), .evt_valid_o(evv0), .evt_ready_i(rdy0)
  );

  xbus_spike_responder #(.BASE_ADDR(B), .FIFO_DEPTH(16), .WAIT_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .xbus_adr_i(adr), .xbus_dat_i(wdat), .xbus_tag_i(tag),
    .xbus_we_i(we), .xbus_sel_i(sel), .xbus_stb_i(stb1), .xbus_cyc_i(cyc1),
    .xbus_dat_o(dat1), .xbus_ack_o(ack1), .xbus_err_o(err1),
    .evt_data_o(evd1), .evt_valid_o(evv1), .evt_ready_i(rdy1)
  );

  task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag_s, got, exp);
    end
  endtask

  // One bus transfer; resp = NONE/ACK/ERR, lat = cycles from stb to response.
  task automatic xfer(input int inst, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int resp, output int lat);
    resp = RESP_NONE;
    rd   = '0;
    lat  = 0;
    @(negedge clk);
    adr = a; wdat = d; we = w; sel = s;
    if (inst == 0) begin stb0 = 1'b1; cyc0 = 1'b1; end
    else           begin stb1 = 1'b1; cyc1 = 1'b1; end
    @(posedge clk); #1;
    stb0 = 1'b0; stb1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((inst == 0) ? (ack0 || err0) : (ack1 || err1)) begin
        resp = ((inst == 0) ? ack0 : ack1) ? RESP_ACK : RESP_ERR;
        rd   = (inst == 0) ? dat0 : dat1;
        lat  = n;
        break;
      end
    end
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc1 = 1'b0;
  endtask

  task automatic reg_wr(input int inst, input string t, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int exp_resp);
    logic [31:0] r;
    int resp, lat;
    xfer(inst, 1'b1, a, d, s, r, resp, lat);
    check({t, "_resp"}, resp, exp_resp);
  endtask

  task automatic reg_rd(input int inst, input string t, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    int resp, lat;
    xfer(inst, 1'b0, a, 32'h0, 4'hF, r, resp, lat);
    check({t, "_resp"}, resp, RESP_ACK);
    check(t, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    int resp, lat, acks, seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {29'b0, ack0, err0, evv0}, 32'h0);
    check("rst_dat", dat0, 32'h0);
    check("rst_evd", evd0, 32'h0);
    rst = 1'b0;

    xfer(0, 1'b0, B + 32'h04, 32'h0, 4'hF, r, resp, lat);
    check("status0_resp", resp, RESP_ACK);
    check("status0_lat", lat, 1);
    check("status0", r, 32'h0000_0001);
    reg_rd(0, "scratch0", B + 32'h0C, 32'h0);

    // Scratch byte lanes
    reg_wr(0, "scr_wr", B + 32'h0C, 32'hDEAD_BEEF, 4'hF, RESP_ACK);
    reg_wr(0, "scr_wr_b", B + 32'h0C, 32'h1122_3344, 4'b0101, RESP_ACK);
    reg_rd(0, "scr_bytes", B + 32'h0C, 32'hDE22_BE44);

    // Push and drain
    reg_wr(0, "ctrl_en", B + 32'h00, 32'h1, 4'hF, RESP_ACK);
    reg_wr(0, "push1", B + 32'h08, 32'hA5A5_0001, 4'hF, RESP_ACK);
    reg_wr(0, "push2", B + 32'h08, 32'hA5A5_0002, 4'hF, RESP_ACK);
    reg_rd(0, "status2", B + 32'h04, 32'h0000_0200);
    @(negedge clk);
    rdy0 = 1'b1;
    #1;
    check("drain_v0", 32'(evv0), 32'h1);
    check("drain_d0", evd0, 32'hA5A5_0001);
    @(negedge clk);
    check("drain_d1", evd0, 32'hA5A5_0002);
    @(negedge clk);
    check("drain_empty", 32'(evv0), 32'h0);
    rdy0 = 1'b0;
    reg_rd(0, "status_drained", B + 32'h04, 32'h0000_0001);

    // Overflow with enable = 0
    reg_wr(0, "ctrl_dis", B + 32'h00, 32'h0, 4'hF, RESP_ACK);
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b1, B + 32'h08, 32'h100 + i, 4'hF, r, resp, lat);
      if (resp == RESP_ACK) acks++;
    end
    check("ovf_acks", acks, 16);
    check("ovf_valid_off", 32'(evv0), 32'h0);
    reg_wr(0, "push17", B + 32'h08, 32'h0000_0117, 4'hF, RESP_ERR);
    reg_rd(0, "status_ovf", B + 32'h04, 32'h0001_1002);
    reg_wr(0, "ovf_clr", B + 32'h04, 32'h0001_0000, 4'hF, RESP_ACK);
    reg_rd(0, "status_ovf_clr", B + 32'h04, 32'h0000_1002);
    reg_wr(0, "flush_only", B + 32'h00, 32'h2, 4'hF, RESP_ACK);
    reg_rd(0, "status_flushed", B + 32'h04, 32'h0000_0001);

    // Error responses, no state change
    xfer(0, 1'b0, B + 32'h08, 32'h0, 4'hF, r, resp, lat);
    check("rd_push_resp", resp, RESP_ERR);
    reg_wr(0, "push_sel3", B + 32'h08, 32'h0BAD_0BAD, 4'h3, RESP_ERR);
    reg_rd(0, "status_after_err", B + 32'h04, 32'h0000_0001);
    reg_wr(0, "off20", B + 32'h20, 32'hFFFF_FFFF, 4'hF, RESP_ERR);
`ifdef XBUS_SPIKE_TSTAMP_EN
    reg_wr(0, "tstamp_wr", B + 32'h10, 32'h0, 4'hF, RESP_ACK);
`else
    reg_wr(0, "tstamp_off", B + 32'h10, 32'h0, 4'hF, RESP_ERR);
`endif
    xfer(0, 1'b1, 32'h1000_000C, 32'h0, 4'hF, r, resp, lat);
    check("miss_resp", resp, RESP_NONE);
    reg_rd(0, "scr_after_err", B + 32'h0C, 32'hDE22_BE44);
    reg_wr(0, "ctrl_nosel0", B + 32'h00, 32'h1, 4'hE, RESP_ACK);
    reg_rd(0, "ctrl_nosel0_rd", B + 32'h00, 32'h0);

    // Flush with concurrent pop
    reg_wr(0, "ctrl_en2", B + 32'h00, 32'h1, 4'hF, RESP_ACK);
    for (int i = 0; i < 4; i++)
      reg_wr(0, "push_b", B + 32'h08, 32'hB000_0000 + i, 4'hF, RESP_ACK);
    @(negedge clk);
    adr = B; wdat = 32'h3; we = 1'b1; sel = 4'hF; stb0 = 1'b1; cyc0 = 1'b1; rdy0 = 1'b1;
    #1;
    check("fl_head0", evd0, 32'hB000_0000);
    @(posedge clk); #1;
    stb0 = 1'b0;
    @(negedge clk);
    check("fl_ack", 32'(ack0), 32'h1);
    check("fl_one_pop", evd0, 32'hB000_0001);
    @(posedge clk); #1;
    cyc0 = 1'b0; rdy0 = 1'b0;
    @(negedge clk);
    check("fl_empty", 32'(evv0), 32'h0);
    reg_rd(0, "fl_status", B + 32'h04, 32'h0000_0001);
    reg_rd(0, "fl_ctrl", B + 32'h00, 32'h0000_0001);

    // Wait states (instance 1)
    xfer(1, 1'b1, B + 32'h0C, 32'h1234_5678, 4'hF, r, resp, lat);
    check("w_wr_resp", resp, RESP_ACK);
    check("w_wr_lat", lat, 4);
    xfer(1, 1'b0, B + 32'h0C, 32'h0, 4'hF, r, resp, lat);
    check("w_rd_lat", lat, 4);
    check("w_rd", r, 32'h1234_5678);

    // Abort: cyc dropped in cycle 2
    @(negedge clk);
    adr = B + 32'h0C; wdat = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF; stb1 = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0;
    @(posedge clk); #1;
    cyc1 = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    check("abort_noresp", seen, 0);
    reg_rd(1, "abort_scr", B + 32'h0C, 32'h1234_5678);

    // Reset in the middle of a transfer
    reg_wr(1, "w_push", B + 32'h08, 32'hC0DE_0001, 4'hF, RESP_ACK);
    reg_rd(1, "w_status1", B + 32'h04, 32'h0000_0100);
    @(negedge clk);
    adr = B + 32'h0C; wdat = 32'hAAAA_AAAA; we = 1'b1; sel = 4'hF; stb1 = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    check("rst_mid_noresp", seen, 0);
    cyc1 = 1'b0;
    reg_rd(1, "rst_mid_status", B + 32'h04, 32'h0000_0001);
    reg_rd(1, "rst_mid_scr", B + 32'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got %0d exp done", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule
